// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and widths for the MULT/MULTU sequential multiplier
package mips_pkg;
    localparam int MUL_WIDTH = 32;
    localparam int MUL_CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;
endpackage

// File: rtl/ADD.sv
// rtl/ADD.sv - W-bit ripple-carry adder used for the multiplier partial sum
module ADD #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_sum,
    output logic         o_cout
);
    logic w_c;

    always_comb begin
        w_c   = i_cin;
        o_sum = '0;
        for (int i = 0; i < W; i++) begin
            o_sum[i] = i_a[i] ^ i_b[i] ^ w_c;
            w_c      = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
        end
        o_cout = w_c;
    end
endmodule

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - radix-2 shift-add multiplier with start/busy/done handshake
// Optional signed MULT support is enabled by defining MULT_SIGNED_EN.
module seq_multiplier
    import mips_pkg::*;
#(
    parameter int WIDTH     = MUL_WIDTH,
    parameter bit SKIP_ZERO = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    mul_state_t         r_state;
    logic [MUL_CNT_W-1:0] r_count;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_mcand;
    logic               r_sign;
    logic               r_busy;
    logic               r_done;

    logic [WIDTH-1:0]   w_a_in;
    logic [WIDTH-1:0]   w_b_in;
    logic               w_sign_in;
    logic [WIDTH-1:0]   w_add_sum;
    logic               w_add_cout;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_shift;
    logic [2*WIDTH-1:0] w_run_next;
    logic               w_last;

`ifdef MULT_SIGNED_EN
    // Signed operands are multiplied as magnitudes; -2^31 maps onto unsigned 2^31.
    assign w_a_in    = (signed_op && op_a[WIDTH-1]) ? (~op_a + 1'b1) : op_a;
    assign w_b_in    = (signed_op && op_b[WIDTH-1]) ? (~op_b + 1'b1) : op_b;
    assign w_sign_in = signed_op & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
`else
    logic w_unused_signed_op;
    assign w_unused_signed_op = signed_op;
    assign w_a_in    = op_a;
    assign w_b_in    = op_b;
    assign w_sign_in = 1'b0;
`endif

    ADD #(.W(WIDTH)) u_add (
        .i_a    (r_hi),
        .i_b    (r_mcand),
        .i_cin  (1'b0),
        .o_sum  (w_add_sum),
        .o_cout (w_add_cout)
    );

    assign w_last     = (r_count == MUL_CNT_W'(WIDTH - 1));
    assign w_sum      = r_lo[0] ? {w_add_cout, w_add_sum} : {1'b0, r_hi};
    assign w_shift    = {w_sum, r_lo[WIDTH-1:1]};
    assign w_run_next = (w_last && r_sign) ? (~w_shift + 1'b1) : w_shift;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_count <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_mcand <= '0;
            r_sign  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_busy  <= 1'b1;
                        r_count <= '0;
                        r_hi    <= '0;
                        r_mcand <= w_a_in;
                        r_sign  <= w_sign_in;
                        if (SKIP_ZERO && ((op_a == '0) || (op_b == '0))) begin
                            r_lo    <= '0;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_lo    <= w_b_in;
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    {r_hi, r_lo} <= w_run_next;
                    r_count      <= r_count + 1'b1;
                    if (w_last) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;
endmodule
